mem_master: RTL and testbench

Command-driven initiator for the single-port synchronous memory model. It accepts read and write commands, optionally as incrementing bursts, on a valid/ready command interface. It drives the memory's addr/wr_en/rd_en/wdata pins and returns read data on a valid/ready response interface. It sits between testbench or processor-side logic and the memory model.

---
 rtl/mem_master_pkg.sv | 19 +
 rtl/mem_master.sv | 180 ++++++++++++++++++
 tb/tb_mem_master.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and default widths for the mem_master command initiator.
// The bench imports the same defaults so both sides agree on port widths.
package mem_master_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 4;

    // RD_ISSUE strobes the memory, RD_CAPT takes the registered read data,
    // and RD_RESP holds the beat until the consumer takes it.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_master.sv
// mem_master: command-driven initiator for the single-port synchronous memory.
// Accepts read/write commands on a valid/ready interface, drives registered
// memory strobes, and returns read beats on a valid/ready response interface.
//
// Build option MEM_MASTER_BURST_EN:
//   defined   - cmd_len is honoured; a command carries cmd_len+1 beats with
//               incrementing, wrapping addresses.
//   undefined - cmd_len is ignored; every command is a single beat and the
//               beat counter does not exist.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,

    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_beat;

    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  rsp_fire;

    // Handshakes are only meaningful in the state that owns the interface;
    // the ready/valid registers already imply it, the state term makes it explicit.
    assign cmd_fire = (state == IDLE)    && cmd_valid && cmd_ready;
    assign wr_fire  = (state == WRITE)   && wr_valid  && wr_ready;
    assign rsp_fire = (state == RD_RESP) && rsp_valid && rsp_ready;

`ifdef MEM_MASTER_BURST_EN
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_q;

    // The current beat is final when the counter reaches the latched length;
    // an all-ones length therefore yields 2**LEN_WIDTH beats.
    assign last_beat = (beat_q == len_q);

    // Beat counter: cleared on acceptance, advanced on every completed beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            beat_q <= '0;
        end else if (cmd_fire) begin
            len_q  <= cmd_len;
            beat_q <= '0;
        end else if (wr_fire || rsp_fire) begin
            beat_q <= beat_q + 1'b1;
        end
    end
`else
    // Length is not used in single-beat builds; fold it into a sink net.
    logic unused_len;
    assign unused_len = ^cmd_len;
    assign last_beat  = 1'b1;
`endif

    // Main FSM with every interface and memory-side output registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wdata <= '0;
        end else begin
            // Strobes are single-cycle pulses unless a state re-asserts them.
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        addr_q    <= cmd_addr;
                        if (cmd_write) begin
                            state    <= WRITE;
                            wr_ready <= 1'b1;
                        end else begin
                            // Issue the first read straight from the command so
                            // RD_ISSUE already has rd_en on the memory pins.
                            state     <= RD_ISSUE;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cmd_addr;
                        end
                    end
                end

                WRITE: begin
                    if (wr_fire) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= wr_data;
                        addr_q    <= addr_q + 1'b1;
                        if (last_beat) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end

                RD_ISSUE: begin
                    // Memory registers rdata on this edge; it is not valid yet.
                    state <= RD_CAPT;
                end

                RD_CAPT: begin
                    rsp_data  <= mem_rdata;
                    rsp_last  <= last_beat;
                    rsp_valid <= 1'b1;
                    state     <= RD_RESP;
                end

                RD_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            addr_q    <= addr_q + 1'b1;
                            mem_addr  <= addr_q + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    wr_ready  <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural single-port memory.
// Works with and without MEM_MASTER_BURST_EN; burst-only scenarios fall back
// to one command per beat when the option is off.
`timescale 1ns/1ps
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int LW = DEF_LEN_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem_model [0:(1<<AW)-1] = '{default: 8'hFF};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Synchronous memory: writes and registered reads on the strobe edge.
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem_model[mem_addr];
    end

    mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return just after the accepting edge (cycle 1).
    task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int guard;
        guard = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_accept_timeout got=%b exp=1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_last !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_last got=%b exp=0", rsp_last); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=00", rsp_data); end
        n_cmp++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        n_cmp++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_strobes got=%b%b exp=00", mem_wr_en, mem_rd_en); end
        n_cmp++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata got=%h exp=00", mem_wdata); end
        reset = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rel_cmd_ready_early got=%b exp=0", cmd_ready); end
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_cmd_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_write_read();
        issue_cmd(1'b1, 4'h3, 4'h0);
        n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_wr_ready got=%b exp=1", wr_ready); end
        n_cmp++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy_ready got=%b%b exp=10", busy, cmd_ready); end
        wr_valid = 1'b1; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL sw_wr_en got=%b exp=1", mem_wr_en); end
        n_cmp++; if (mem_addr !== 4'h3) begin n_fail++; $display("FAIL sw_addr got=%h exp=3", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL sw_wdata got=%h exp=a5", mem_wdata); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL sw_wr_ready_done got=%b exp=0", wr_ready); end
        tick();
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL sw_wr_en_pulse got=%b exp=0", mem_wr_en); end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sw_idle got=%b%b exp=10", cmd_ready, busy); end
        n_cmp++; if (mem_model[3] !== 8'hA5) begin n_fail++; $display("FAIL sw_mem3 got=%h exp=a5", mem_model[3]); end

        issue_cmd(1'b0, 4'h3, 4'h0);
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 4'h3) begin n_fail++; $display("FAIL sr_issue got=%b/%h exp=1/3", mem_rd_en, mem_addr); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sr_valid_c1 got=%b exp=0", rsp_valid); end
        tick();
        n_cmp++; if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sr_c2 got=%b%b exp=00", mem_rd_en, rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sr_valid_c3 got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL sr_data got=%h exp=a5", rsp_data); end
        n_cmp++; if (rsp_last !== 1'b1) begin n_fail++; $display("FAIL sr_last got=%b exp=1", rsp_last); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sr_done got=%b%b%b exp=010", rsp_valid, cmd_ready, busy); end
    endtask

    task automatic test_wrap();
        logic [3:0] ea;
        logic [7:0] ed;
        logic       el;
`ifdef MEM_MASTER_BURST_EN
        issue_cmd(1'b1, 4'hE, 4'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            ea = 4'hE + i[3:0];
            ed = 8'h10 + i[7:0];
`ifdef MEM_MASTER_BURST_EN
            el = (i != 3);
`else
            issue_cmd(1'b1, ea, 4'd3);
            el = 1'b0;
`endif
            wr_valid = 1'b1; wr_data = ed;
            tick();
            wr_valid = 1'b0;
            n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin n_fail++; $display("FAIL wrap_wr%0d got=%b/%h/%h exp=1/%h/%h", i, mem_wr_en, mem_addr, mem_wdata, ea, ed); end
            n_cmp++; if (wr_ready !== el) begin n_fail++; $display("FAIL wrap_wr_ready%0d got=%b exp=%b", i, wr_ready, el); end
        end
        tick();
        n_cmp++; if (cmd_ready !== 1'b1 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL wrap_wr_end got=%b%b exp=10", cmd_ready, mem_wr_en); end

        rsp_ready = 1'b1;
`ifdef MEM_MASTER_BURST_EN
        issue_cmd(1'b0, 4'hE, 4'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            ea = 4'hE + i[3:0];
            ed = 8'h10 + i[7:0];
`ifdef MEM_MASTER_BURST_EN
            el = (i == 3);
`else
            issue_cmd(1'b0, ea, 4'd3);
            el = 1'b1;
`endif
            n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== ea) begin n_fail++; $display("FAIL wrap_rd_issue%0d got=%b/%h exp=1/%h", i, mem_rd_en, mem_addr, ea); end
            tick(); tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== ed) begin n_fail++; $display("FAIL wrap_rd%0d got=%b/%h exp=1/%h", i, rsp_valid, rsp_data, ed); end
            n_cmp++; if (rsp_last !== el) begin n_fail++; $display("FAIL wrap_last%0d got=%b exp=%b", i, rsp_last, el); end
            tick();
        end
        rsp_ready = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_end got=%b%b%b exp=100", cmd_ready, busy, rsp_valid); end
    endtask

    task automatic test_backpressure();
        issue_cmd(1'b0, 4'hE, 4'd1);
        tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h10) begin n_fail++; $display("FAIL bp_beat0 got=%b/%h exp=1/10", rsp_valid, rsp_data); end
`ifdef MEM_MASTER_BURST_EN
        n_cmp++; if (rsp_last !== 1'b0) begin n_fail++; $display("FAIL bp_last0 got=%b exp=0", rsp_last); end
`else
        n_cmp++; if (rsp_last !== 1'b1) begin n_fail++; $display("FAIL bp_last0 got=%b exp=1", rsp_last); end
`endif
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h10 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d got=%b/%h/%b exp=1/10/0", k, rsp_valid, rsp_data, mem_rd_en); end
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hs got=%b exp=0", rsp_valid); end
`ifndef MEM_MASTER_BURST_EN
        n_cmp++; if (mem_rd_en !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_single_end got=%b%b exp=01", mem_rd_en, cmd_ready); end
        issue_cmd(1'b0, 4'hF, 4'd1);
`endif
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 4'hF) begin n_fail++; $display("FAIL bp_beat1_issue got=%b/%h exp=1/f", mem_rd_en, mem_addr); end
        tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h11 || rsp_last !== 1'b1) begin n_fail++; $display("FAIL bp_beat1 got=%b/%h/%b exp=1/11/1", rsp_valid, rsp_data, rsp_last); end
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_end got=%b%b exp=10", cmd_ready, busy); end
    endtask

    task automatic test_bubbles();
        logic [3:0] ea;
        logic [7:0] ed;
`ifdef MEM_MASTER_BURST_EN
        issue_cmd(1'b1, 4'h5, 4'd3);
`endif
        for (int i = 0; i < 4; i++) begin
            ea = 4'h5 + i[3:0];
            ed = 8'h20 + i[7:0];
`ifndef MEM_MASTER_BURST_EN
            issue_cmd(1'b1, ea, 4'd3);
`endif
            if (i == 2) begin
                wr_valid = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    n_cmp++; if (mem_wr_en !== 1'b0 || mem_addr !== 4'h6 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL bub_gap%0d got=%b/%h/%b exp=0/6/1", k, mem_wr_en, mem_addr, wr_ready); end
                end
            end
            wr_valid = 1'b1; wr_data = ed;
            tick();
            wr_valid = 1'b0;
            n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== ea || mem_wdata !== ed) begin n_fail++; $display("FAIL bub_wr%0d got=%b/%h/%h exp=1/%h/%h", i, mem_wr_en, mem_addr, mem_wdata, ea, ed); end
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_model[5+i] !== 8'h20 + i[7:0]) begin n_fail++; $display("FAIL bub_mem%0d got=%h exp=%h", 5+i, mem_model[5+i], 8'h20 + i[7:0]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] ea;
`ifdef MEM_MASTER_BURST_EN
        issue_cmd(1'b1, 4'h9, 4'd7);
`endif
        for (int i = 0; i < 3; i++) begin
            ea = 4'h9 + i[3:0];
`ifndef MEM_MASTER_BURST_EN
            issue_cmd(1'b1, ea, 4'd7);
`endif
            wr_valid = 1'b1; wr_data = 8'h30 + i[7:0];
            tick();
            if (i < 2) wr_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_wr_en !== 1'b0 || mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rmb_mem got=%b/%h/%h exp=0/0/00", mem_wr_en, mem_addr, mem_wdata); end
        n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmb_ctrl got=%b%b%b exp=000", cmd_ready, busy, wr_ready); end
        tick(); tick();
        n_cmp++; if (mem_wr_en !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmb_held got=%b%b exp=00", mem_wr_en, wr_ready); end
        reset = 1'b1;
        wr_valid = 1'b0;
        n_cmp++; if (mem_model[9] !== 8'h30 || mem_model[10] !== 8'h31) begin n_fail++; $display("FAIL rmb_partial got=%h/%h exp=30/31", mem_model[9], mem_model[10]); end
        n_cmp++; if (mem_model[11] !== 8'hFF) begin n_fail++; $display("FAIL rmb_aborted got=%h exp=ff", mem_model[11]); end
        tick();
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmb_rel got=%b%b exp=10", cmd_ready, busy); end
        issue_cmd(1'b1, 4'hC, 4'd0);
        wr_valid = 1'b1; wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (mem_wr_en !== 1'b1 || mem_addr !== 4'hC) begin n_fail++; $display("FAIL rmb_next_wr got=%b/%h exp=1/c", mem_wr_en, mem_addr); end
        tick();
        rsp_ready = 1'b1;
        issue_cmd(1'b0, 4'hC, 4'd0);
        tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin n_fail++; $display("FAIL rmb_next_rd got=%b/%h exp=1/5a", rsp_valid, rsp_data); end
        tick();
        rsp_ready = 1'b0;
    endtask

`ifdef MEM_MASTER_BURST_EN
    task automatic test_max_len();
        int beats;
        beats = 0;
        issue_cmd(1'b1, 4'h0, 4'hF);
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'h40 + i[7:0];
            tick();
            if (mem_wr_en === 1'b1) beats++;
        end
        wr_valid = 1'b0;
        n_cmp++; if (beats != 16) begin n_fail++; $display("FAIL max_len_beats got=%0d exp=16", beats); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL max_len_done got=%b exp=0", wr_ready); end
        tick();
        n_cmp++; if (mem_model[15] !== 8'h4F || mem_model[0] !== 8'h40) begin n_fail++; $display("FAIL max_len_mem got=%h/%h exp=4f/40", mem_model[15], mem_model[0]); end
    endtask
`else
    task automatic test_single_beat();
        rsp_ready = 1'b1;
        issue_cmd(1'b0, 4'h3, 4'd5);
        n_cmp++; if (mem_rd_en !== 1'b1 || mem_addr !== 4'h3) begin n_fail++; $display("FAIL sb_issue got=%b/%h exp=1/3", mem_rd_en, mem_addr); end
        tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1 || rsp_data !== 8'hA5) begin n_fail++; $display("FAIL sb_beat got=%b/%b/%h exp=1/1/a5", rsp_valid, rsp_last, rsp_data); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_c3 got=%b exp=1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_c4 got=%b%b%b exp=010", busy, cmd_ready, rsp_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (mem_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_quiet%0d got=%b%b exp=00", k, mem_rd_en, rsp_valid); end
        end
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write_read();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_reset_mid_burst();
`ifdef MEM_MASTER_BURST_EN
        test_max_len();
`else
        test_single_beat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
